// File: rtl/countdown8_timer_if.sv
// Control/status bundle for the 8-bit cascaded countdown timer.
// The master drives load/start_stop/data; the timer (slave) returns the count and status flags.
interface countdown8_timer_if;
  logic       load;
  logic       start_stop;
  logic [7:0] data;
  logic [7:0] count;
  logic       zero;
  logic       tc;
  logic       running;
  logic       expired;

  modport master (
    output load, start_stop, data,
    input  count, zero, tc, running, expired
  );

  modport slave (
    input  load, start_stop, data,
    output count, zero, tc, running, expired
  );
endinterface

// File: rtl/countdown8_timer.sv
// 8-bit down-counting timer made of two cascaded nibbles (low-nibble borrow decrements the high nibble),
// with a terminal-count pulse, IDLE/RUN/HOLD/EXPIRED control, optional auto-reload and optional BCD.
module countdown8_timer #(
  parameter bit AUTO_RELOAD = 1'b0,
  parameter bit BCD_MODE    = 1'b0
) (
  input  logic            clock,
  input  logic            clear,
  countdown8_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HOLD    = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t     state_p0, state_nxt;
  logic [7:0] count_p0, count_nxt;
  logic [7:0] reload_p0, reload_nxt;
  logic       tc_p0, tc_nxt;
  logic [7:0] loaded;

  // Saturate each nibble to 9 so a BCD counter never holds a non-decimal digit.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (BCD_MODE) begin
      if (hi > 4'd9) hi = 4'd9;
      if (lo > 4'd9) lo = 4'd9;
    end
    return {hi, lo};
  endfunction

  function automatic logic [7:0] dec_count(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd0) begin
      lo = BCD_MODE ? 4'd9 : 4'hF;
      hi = hi - 4'd1;
    end else begin
      lo = lo - 4'd1;
    end
    return {hi, lo};
  endfunction

  always_comb begin
    state_nxt  = state_p0;
    count_nxt  = count_p0;
    reload_nxt = reload_p0;
    tc_nxt     = 1'b0;
    loaded     = clamp_bcd(bus.data);

    if (bus.load) begin
      count_nxt  = loaded;
      reload_nxt = loaded;
      if (loaded == 8'd0)      state_nxt = S_IDLE;
      else if (bus.start_stop) state_nxt = S_RUN;
      else                     state_nxt = S_HOLD;
    end else begin
      case (state_p0)
        S_RUN, S_HOLD: begin
          // Only reachable at zero with auto-reload: an empty reload value has nothing to time.
          if (count_p0 == 8'd0 && reload_p0 == 8'd0) begin
            state_nxt = S_IDLE;
          end else if (!bus.start_stop) begin
            state_nxt = S_HOLD;
          end else if (count_p0 != 8'd0) begin
            count_nxt = dec_count(count_p0);
            state_nxt = S_RUN;
            if (count_p0 == 8'd1) begin
              tc_nxt = 1'b1;
              if (!AUTO_RELOAD) state_nxt = S_EXPIRED;
            end
          end else begin
            // Zero is a real enabled cycle before reloading, giving a period of reload+1.
            count_nxt = reload_p0;
            state_nxt = S_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Stage p0: state, count, reload and tc registers
  always_ff @(posedge clock) begin
    if (clear) begin
      state_p0  <= S_IDLE;
      count_p0  <= 8'd0;
      reload_p0 <= 8'd0;
      tc_p0     <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      count_p0  <= count_nxt;
      reload_p0 <= reload_nxt;
      tc_p0     <= tc_nxt;
    end
  end

  assign bus.count   = count_p0;
  assign bus.zero    = (count_p0 == 8'd0);
  assign bus.tc      = tc_p0;
  assign bus.running = (state_p0 == S_RUN);
  assign bus.expired = (state_p0 == S_EXPIRED);

endmodule
